// File: rtl/snn_timestep_controller.sv
// Timestep sequencer for an 8-neuron spiking layer: fetches input spikes, applies them, and accumulates saturating output counts.
// Define SNN_ARGMAX_EN to include the DECIDE state and the registered argmax winner output.
module snn_timestep_controller #(
  parameter int NUM_TIMESTEPS = 16,
  parameter int CNT_W         = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic               input_spike_valid,
  input  logic [7:0]         input_spike,
  output logic               input_spike_ready,
  output logic [7:0]         layer_spike_out,
  output logic               layer_reset_n,
  input  logic [7:0]         layer_spike_in,
  output logic               busy,
  output logic               done,
  output logic [8*CNT_W-1:0] spike_count,
  output logic [2:0]         winner
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FETCH  = 3'd2,
    S_APPLY  = 3'd3,
    S_SAMPLE = 3'd4,
`ifdef SNN_ARGMAX_EN
    S_DECIDE = 3'd5,
`endif
    S_DONE   = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [7:0]       LAST_TS = 8'(NUM_TIMESTEPS - 1);

  state_e                  state_q;
  logic [7:0][CNT_W-1:0]   cnt_q;
  logic [7:0][CNT_W-1:0]   cnt_d;
  logic [7:0]              ts_q;
  logic [7:0]              spike_out_q;
  logic                    ready_q;
  logic                    busy_q;
  logic                    done_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic b);
    if (b && (v != CNT_MAX)) begin
      sat_inc = v + CNT_W'(1);
    end else begin
      sat_inc = v;
    end
  endfunction

  // Saturating per-neuron count update applied when SAMPLE completes.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = sat_inc(cnt_q[i], layer_spike_in[i]);
    end
  end

`ifdef SNN_ARGMAX_EN
  logic [2:0]       best_idx_s;
  logic [CNT_W-1:0] best_val_s;
  logic [2:0]       winner_q;

  // Argmax scan; strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_idx_s = 3'd0;
    best_val_s = cnt_q[0];
    for (int i = 1; i < 8; i++) begin
      best_idx_s = (cnt_q[i] > best_val_s) ? 3'(i) : best_idx_s;
      best_val_s = (cnt_q[i] > best_val_s) ? cnt_q[i] : best_val_s;
    end
  end

  assign winner = winner_q;
`else
  assign winner = 3'd0;
`endif

  // Sequencer state with all handshake and layer outputs registered alongside it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ts_q        <= 8'd0;
      spike_out_q <= 8'h00;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SNN_ARGMAX_EN
      winner_q    <= 3'd0;
`endif
    end else if (abort && (state_q != S_IDLE)) begin
      state_q     <= S_IDLE;
      spike_out_q <= 8'h00;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_CLEAR;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            ts_q     <= 8'd0;
`ifdef SNN_ARGMAX_EN
            winner_q <= 3'd0;
`endif
          end
        end
        S_CLEAR: begin
          state_q <= S_FETCH;
          ready_q <= 1'b1;
        end
        S_FETCH: begin
          if (input_spike_valid) begin
            state_q     <= S_APPLY;
            spike_out_q <= input_spike;
            ready_q     <= 1'b0;
          end
        end
        S_APPLY: begin
          state_q     <= S_SAMPLE;
          spike_out_q <= 8'h00;
        end
        S_SAMPLE: begin
          cnt_q <= cnt_d;
          ts_q  <= ts_q + 8'd1;
          if (ts_q == LAST_TS) begin
`ifdef SNN_ARGMAX_EN
            state_q <= S_DECIDE;
`else
            state_q <= S_DONE;
            done_q  <= 1'b1;
`endif
          end else begin
            state_q <= S_FETCH;
            ready_q <= 1'b1;
          end
        end
`ifdef SNN_ARGMAX_EN
        S_DECIDE: begin
          winner_q <= best_idx_s;
          state_q  <= S_DONE;
          done_q   <= 1'b1;
        end
`endif
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          spike_out_q <= 8'h00;
          ready_q     <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  // The layer clear follows system reset combinationally so a mid-inference reset wipes membranes at once.
  assign layer_reset_n     = reset_n & (state_q != S_CLEAR);
  assign input_spike_ready = ready_q;
  assign layer_spike_out   = spike_out_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign spike_count       = cnt_q;

endmodule

// File: doc/snn_timestep_controller.md
SNN_TIMESTEP_CONTROLLER -- requirements
Module: snn_timestep_controller

Interface
REQ-001 SHALL have parameter NUM_TIMESTEPS, default 16; timesteps per inference, range 1..255.
REQ-002 SHALL have parameter CNT_W, default 5; width of each per-neuron spike counter, range 1..8.
REQ-003 SHALL have port clk, input, 1; the only clock, rising edge.
REQ-004 SHALL have port reset_n, input, 1; asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1; requests one inference, sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1; cancels a running inference.
REQ-007 SHALL have port input_spike_valid, input, 1; the source offers one timestep of input spikes.
REQ-008 SHALL have port input_spike, input, 8; input spike vector.
REQ-009 SHALL have port input_spike_ready, output, 1; the controller accepts input_spike.
REQ-010 SHALL have port layer_spike_out, output, 8; registered spikes driven to the 8-neuron layer.
REQ-011 SHALL have port layer_reset_n, output, 1; active-low clear of the layer membrane potentials.
REQ-012 SHALL have port layer_spike_in, input, 8; output spikes from the layer.
REQ-013 SHALL have port busy, output, 1; high in every state except IDLE.
REQ-014 SHALL have port done, output, 1; one-cycle completion pulse.
REQ-015 SHALL have port spike_count, output, 8*CNT_W; per-neuron counts, neuron i at bits [i*CNT_W +: CNT_W].
REQ-016 SHALL have port winner, output, 3; index of the neuron with the highest count.

Function
REQ-017 SHALL implement the states IDLE, CLEAR, FETCH, APPLY, SAMPLE, DECIDE and DONE, advancing on rising clk edges.
REQ-018 SHALL move from IDLE to CLEAR on start=1; SHALL ignore start in every other state.
REQ-019 In CLEAR, SHALL drive layer_reset_n=0 for exactly one cycle, zero all counters and the timestep counter, then go to FETCH.
REQ-020 In FETCH, SHALL drive input_spike_ready=1; on input_spike_valid=1, SHALL capture input_spike and go to APPLY; otherwise SHALL stay in FETCH.
REQ-021 In APPLY, SHALL drive layer_spike_out with the captured vector for exactly one cycle; in all other states layer_spike_out SHALL be 8'h00.
REQ-022 In SAMPLE, SHALL add each bit layer_spike_in[i] to count i, saturating at 2^CNT_W-1 with no wrap; SHALL increment the timestep counter.
REQ-023 From SAMPLE, SHALL go to DECIDE when the completed timestep is number NUM_TIMESTEPS; otherwise SHALL go to FETCH.
REQ-024 In DECIDE, SHALL register winner as the argmax of the counts, with ties resolved to the lowest index; SHALL then go to DONE.
REQ-025 In DONE, SHALL assert done for one cycle and return to IDLE.
REQ-026 With input_spike_valid held high, done SHALL be high during cycle 3*NUM_TIMESTEPS+3 after the clk edge that samples start.
REQ-027 spike_count and winner SHALL hold their values from DONE until the next CLEAR.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with no done pulse, layer_spike_out=0 and counts held; abort SHALL take priority over all other transitions.
REQ-029 input_spike_ready SHALL be 0 outside FETCH; a valid input while not ready SHALL NOT be consumed.

Reset
REQ-030 While reset_n=0, SHALL force state IDLE, busy=0, done=0, input_spike_ready=0, layer_spike_out=8'h00, all counts 0 and winner=0.
REQ-031 layer_reset_n SHALL equal reset_n AND (state != CLEAR), so the layer clears immediately on a system reset, including a reset in the middle of an inference.

Configuration
REQ-032 With macro SNN_ARGMAX_EN defined, DECIDE and the winner logic SHALL be present as specified.
REQ-033 Without SNN_ARGMAX_EN, DECIDE SHALL be omitted: SAMPLE SHALL go directly to DONE, winner SHALL be tied to 3'd0, and done latency SHALL be 3*NUM_TIMESTEPS+2.

Verification
REQ-034 Reset: assert reset_n=0 mid-APPLY -> busy=0, layer_reset_n=0, layer_spike_out=00 and counts=0 immediately.
REQ-035 Basic inference: NUM_TIMESTEPS=4, valid held high, layer_spike_in=8'h05 in every SAMPLE -> counts 4,0,4,0,0,0,0,0, winner=0, done at cycle 15.
REQ-036 Saturation: CNT_W=2, NUM_TIMESTEPS=4, layer_spike_in=8'hFF -> every count=3 with no wrap; winner=0.
REQ-037 Stall: input_spike_valid low for 5 cycles in the second FETCH -> ready stays 1, no APPLY occurs, done is delayed by exactly 5 cycles.
REQ-038 Abort and start while busy: a start pulse during SAMPLE is ignored; abort in FETCH -> IDLE next cycle, no done, busy=0.
REQ-039 Argmax: layer_spike_in=8'h80 for 3 timesteps and 8'h02 for 1 timestep -> winner=7; with SNN_ARGMAX_EN undefined -> winner=0 and done at cycle 14.
